// File: rtl/ltl_monitor_stage.sv
// Pipeline stage of the runtime LTL monitor chain: forwards the symbol stream and
// collects automaton reports into sticky flags, saturating counters and a first-report capture.
module ltl_monitor_stage #(
  parameter int SYM_W    = 8,
  parameter int NUM_PROP = 4,
  parameter int NUM_REP  = 4,
  parameter int CNT_W    = 16,
  localparam int NBITS   = NUM_PROP * NUM_REP,
  localparam int PW      = (NUM_PROP > 1) ? $clog2(NUM_PROP) : 1,
  localparam int RW      = (NUM_REP > 1) ? $clog2(NUM_REP) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      sym_reset,
  input  logic [SYM_W-1:0]          top_symbols,
  input  logic [NBITS-1:0]          rep_in,
  input  logic [NUM_PROP-1:0]       prop_en,
  input  logic                      clr,
  output logic [SYM_W-1:0]          out_symbols,
  output logic                      out_sym_reset,
  output logic [NBITS-1:0]          rep_q,
  output logic [NBITS-1:0]          sticky,
  output logic [NUM_PROP*CNT_W-1:0] viol_cnt,
  output logic [CNT_W-1:0]          sym_cnt,
  output logic                      first_valid,
  output logic [PW-1:0]             first_prop,
  output logic [RW-1:0]             first_rep,
  output logic [CNT_W-1:0]          first_stamp,
  output logic                      irq
);

  typedef enum logic {IDLE, CAPT} state_t;

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   out_symbols_q, out_symbols_d;
  logic               out_sym_reset_q, out_sym_reset_d;
  logic [NBITS-1:0]   rep_q_q, rep_q_d;
  logic [NBITS-1:0]   sticky_q, sticky_d;
  logic [CNT_W-1:0]   viol_q [NUM_PROP];
  logic [CNT_W-1:0]   viol_d [NUM_PROP];
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic               first_valid_q, first_valid_d;
  logic [PW-1:0]      first_prop_q, first_prop_d;
  logic [RW-1:0]      first_rep_q, first_rep_d;
  logic [CNT_W-1:0]   first_stamp_q, first_stamp_d;
  logic               irq_q, irq_d;

  logic [NBITS-1:0]   hit;
  logic [PW-1:0]      lo_prop;
  logic [RW-1:0]      lo_rep;

  // Qualified reports and the lowest-index hit (descending scan leaves the lowest last).
  always_comb begin
    hit     = '0;
    lo_prop = '0;
    lo_rep  = '0;
    for (int p = 0; p < NUM_PROP; p++) begin
      for (int r = 0; r < NUM_REP; r++) begin
        hit[p*NUM_REP + r] = run & prop_en[p] & rep_in[p*NUM_REP + r];
      end
    end
    for (int p = NUM_PROP - 1; p >= 0; p--) begin
      for (int r = NUM_REP - 1; r >= 0; r--) begin
        if (hit[p*NUM_REP + r]) begin
          lo_prop = PW'(p);
          lo_rep  = RW'(r);
        end
      end
    end
  end

  always_comb begin
    out_symbols_d   = run ? top_symbols : out_symbols_q;
    out_sym_reset_d = sym_reset;
    rep_q_d         = (run && !sym_reset) ? hit : '0;
    sticky_d        = (clr ? '0 : sticky_q) | hit;

    if (sym_reset)
      sym_cnt_d = '0;
    else if (run)
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
    else
      sym_cnt_d = sym_cnt_q;

    for (int p = 0; p < NUM_PROP; p++) begin
      viol_d[p] = clr ? '0 : viol_q[p];
      if ((|hit[p*NUM_REP +: NUM_REP]) && (viol_d[p] != {CNT_W{1'b1}}))
        viol_d[p] = viol_d[p] + CNT_W'(1);
    end

    state_d       = state_q;
    first_valid_d = first_valid_q;
    first_prop_d  = first_prop_q;
    first_rep_d   = first_rep_q;
    first_stamp_d = first_stamp_q;
    // A clear re-arms the capture, so a hit in the same cycle is taken as the new first report.
    if ((|hit) && (state_q == IDLE || clr)) begin
      state_d       = CAPT;
      first_valid_d = 1'b1;
      first_prop_d  = lo_prop;
      first_rep_d   = lo_rep;
      first_stamp_d = sym_cnt_q;
    end else if (clr) begin
      state_d       = IDLE;
      first_valid_d = 1'b0;
      first_prop_d  = '0;
      first_rep_d   = '0;
      first_stamp_d = '0;
    end
    irq_d = (state_d == CAPT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      out_symbols_q   <= '0;
      out_sym_reset_q <= 1'b0;
      rep_q_q         <= '0;
      sticky_q        <= '0;
      sym_cnt_q       <= '0;
      for (int p = 0; p < NUM_PROP; p++) viol_q[p] <= '0;
      first_valid_q   <= 1'b0;
      first_prop_q    <= '0;
      first_rep_q     <= '0;
      first_stamp_q   <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_symbols_q   <= out_symbols_d;
      out_sym_reset_q <= out_sym_reset_d;
      rep_q_q         <= rep_q_d;
      sticky_q        <= sticky_d;
      sym_cnt_q       <= sym_cnt_d;
      for (int p = 0; p < NUM_PROP; p++) viol_q[p] <= viol_d[p];
      first_valid_q   <= first_valid_d;
      first_prop_q    <= first_prop_d;
      first_rep_q     <= first_rep_d;
      first_stamp_q   <= first_stamp_d;
      irq_q           <= irq_d;
    end
  end

  always_comb begin
    viol_cnt = '0;
    for (int p = 0; p < NUM_PROP; p++) viol_cnt[p*CNT_W +: CNT_W] = viol_q[p];
  end

  assign out_symbols   = out_symbols_q;
  assign out_sym_reset = out_sym_reset_q;
  assign rep_q         = rep_q_q;
  assign sticky        = sticky_q;
  assign sym_cnt       = sym_cnt_q;
  assign first_valid   = first_valid_q;
  assign first_prop    = first_prop_q;
  assign first_rep     = first_rep_q;
  assign first_stamp   = first_stamp_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_ltl_monitor_stage.sv
// Scoreboard bench for ltl_monitor_stage: a default instance plus a CNT_W=4 instance on the
// same inputs, checked against a behavioural model of the stage.
module tb_ltl_monitor_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run, sym_reset, clr;
  logic [7:0]  top_symbols;
  logic [15:0] rep_in;
  logic [3:0]  prop_en;

  logic [7:0]  out_symbols, s_out_symbols;
  logic        out_sym_reset, s_out_sym_reset;
  logic [15:0] rep_q, s_rep_q, sticky, s_sticky;
  logic [63:0] viol_cnt;
  logic [15:0] s_viol_cnt;
  logic [15:0] sym_cnt, first_stamp;
  logic [3:0]  s_sym_cnt, s_first_stamp;
  logic        first_valid, s_first_valid, irq, s_irq;
  logic [1:0]  first_prop, s_first_prop, first_rep, s_first_rep;

  ltl_monitor_stage dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sym_reset(sym_reset),
    .top_symbols(top_symbols), .rep_in(rep_in), .prop_en(prop_en), .clr(clr),
    .out_symbols(out_symbols), .out_sym_reset(out_sym_reset), .rep_q(rep_q),
    .sticky(sticky), .viol_cnt(viol_cnt), .sym_cnt(sym_cnt),
    .first_valid(first_valid), .first_prop(first_prop), .first_rep(first_rep),
    .first_stamp(first_stamp), .irq(irq)
  );

  ltl_monitor_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run), .sym_reset(sym_reset),
    .top_symbols(top_symbols), .rep_in(rep_in), .prop_en(prop_en), .clr(clr),
    .out_symbols(s_out_symbols), .out_sym_reset(s_out_sym_reset), .rep_q(s_rep_q),
    .sticky(s_sticky), .viol_cnt(s_viol_cnt), .sym_cnt(s_sym_cnt),
    .first_valid(s_first_valid), .first_prop(s_first_prop), .first_rep(s_first_rep),
    .first_stamp(s_first_stamp), .irq(s_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sym;
    logic        srst;
    logic [15:0] rep;
    logic [15:0] sticky;
    logic [63:0] viol;
    logic [15:0] viol4;
    logic [15:0] scnt;
    logic        fv;
    logic [1:0]  fp;
    logic [1:0]  fr;
    logic [15:0] fs;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0]  m_sym;
  logic        m_srst, m_capt, m_fv;
  logic [15:0] m_rep, m_sticky, m_scnt, m_fs;
  logic [1:0]  m_fp, m_fr;
  int          m_viol [4];

  task automatic model_reset();
    m_sym = '0; m_srst = 0; m_capt = 0; m_fv = 0;
    m_rep = '0; m_sticky = '0; m_scnt = '0; m_fs = '0; m_fp = '0; m_fr = '0;
    for (int p = 0; p < 4; p++) m_viol[p] = 0;
    sbq.delete();
  endtask

  // Drive one cycle, advance the model, queue the expected outputs, sample at the falling edge.
  task automatic step(input logic r, input logic sr, input logic [7:0] s,
                      input logic [15:0] rp, input logic [3:0] en, input logic c);
    logic [15:0] h;
    logic        got;
    exp_t        x;
    run = r; sym_reset = sr; top_symbols = s; rep_in = rp; prop_en = en; clr = c;
    h = '0;
    for (int i = 0; i < 16; i++) h[i] = r && rp[i] && en[i/4];
    if (h != 0 && (!m_capt || c)) begin
      got = 0;
      for (int i = 0; i < 16; i++) begin
        if (h[i] && !got) begin
          m_fp = 2'(i / 4); m_fr = 2'(i % 4); got = 1;
        end
      end
      m_fs = m_scnt; m_fv = 1; m_capt = 1;
    end else if (c) begin
      m_capt = 0; m_fv = 0; m_fp = 0; m_fr = 0; m_fs = 0;
    end
    if (r) m_sym = s;
    m_srst = sr;
    m_rep = (r && !sr) ? h : 16'h0;
    m_scnt = sr ? 16'h0 : (r ? m_scnt + 16'h1 : m_scnt);
    m_sticky = (c ? 16'h0 : m_sticky) | h;
    for (int p = 0; p < 4; p++) begin
      if (c) m_viol[p] = 0;
      if (h[p*4 +: 4] != 0 && m_viol[p] < 65535) m_viol[p]++;
    end
    x.sym = m_sym; x.srst = m_srst; x.rep = m_rep; x.sticky = m_sticky; x.scnt = m_scnt;
    x.fv = m_fv; x.fp = m_fp; x.fr = m_fr; x.fs = m_fs; x.irq = m_capt;
    for (int p = 0; p < 4; p++) begin
      x.viol[p*16 +: 16] = 16'(m_viol[p]);
      x.viol4[p*4 +: 4]  = (m_viol[p] > 15) ? 4'hF : 4'(m_viol[p]);
    end
    sbq.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; run = 0; sym_reset = 0; clr = 0; top_symbols = 8'hFF;
    rep_in = 16'hFFFF; prop_en = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_symbols, out_sym_reset, rep_q, sticky, viol_cnt, sym_cnt, first_valid,
         first_prop, first_rep, first_stamp, irq} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_state: got nonzero outputs sticky=%h sym_cnt=%h irq=%b, expected all 0", sticky, sym_cnt, irq);
    end
    n_cmp++;
    if ({s_sticky, s_viol_cnt, s_sym_cnt, s_irq} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_state_cnt4: got sticky=%h viol=%h, expected 0", s_sticky, s_viol_cnt);
    end
    reset_n = 1;
    model_reset();
    step(0, 0, 8'h00, 16'hFFFF, 4'hF, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (sticky !== e.sticky || irq !== e.irq || sym_cnt !== e.scnt) begin
      n_fail++; $display("[TB] FAIL reset_run0_ignored: got sticky=%h irq=%b, expected sticky=%h irq=%b", sticky, irq, e.sticky, e.irq);
    end
  endtask

  task automatic test_stream();
    logic [7:0] syms [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, syms[i], 16'h0, 4'hF, 0);
      e = sbq.pop_front();
      n_cmp++;
      if (out_symbols !== e.sym || sym_cnt !== e.scnt) begin
        n_fail++; $display("[TB] FAIL stream_%0d: got sym=%h cnt=%0d, expected sym=%h cnt=%0d", i, out_symbols, sym_cnt, e.sym, e.scnt);
      end
    end
    step(0, 0, 8'h99, 16'h0, 4'hF, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (out_symbols !== 8'h33 || sym_cnt !== 16'd3 || out_symbols !== e.sym) begin
      n_fail++; $display("[TB] FAIL stream_hold: got sym=%h cnt=%0d, expected sym=33 cnt=3", out_symbols, sym_cnt);
    end
  endtask

  task automatic test_capture();
    step(0, 1, 8'h00, 16'h0, 4'hF, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (sym_cnt !== 16'd0 || out_sym_reset !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sym_restart: got cnt=%0d osr=%b, expected cnt=0 osr=1", sym_cnt, out_sym_reset);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'(i + 1), 16'h0, 4'hF, 0);
      e = sbq.pop_front();
    end
    step(1, 0, 8'h66, 16'h0240, 4'hF, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (first_prop !== 2'd1 || first_rep !== 2'd2 || first_stamp !== 16'd5 || first_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL capture_first: got p=%0d r=%0d stamp=%0d v=%b, expected p=1 r=2 stamp=5 v=1", first_prop, first_rep, first_stamp, first_valid);
    end
    n_cmp++;
    if (sticky !== 16'h0240 || rep_q !== e.rep || viol_cnt !== e.viol || viol_cnt[16 +: 32] !== 32'h0001_0001) begin
      n_fail++; $display("[TB] FAIL capture_sticky_cnt: got sticky=%h viol=%h, expected sticky=0240 viol=%h", sticky, viol_cnt, e.viol);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++; $display("[TB] FAIL capture_irq: got irq=%b, expected 1", irq);
    end
  endtask

  task automatic test_clr_in_capt();
    step(1, 0, 8'h77, 16'h8000, 4'hF, 1);
    e = sbq.pop_front();
    n_cmp++;
    if (sticky !== 16'h8000 || viol_cnt !== 64'h0001_0000_0000_0000 || viol_cnt !== e.viol) begin
      n_fail++; $display("[TB] FAIL clr_hit_counts: got sticky=%h viol=%h, expected sticky=8000 viol=%h", sticky, viol_cnt, e.viol);
    end
    n_cmp++;
    if (first_prop !== 2'd3 || first_rep !== 2'd3 || irq !== 1'b1 || first_stamp !== e.fs) begin
      n_fail++; $display("[TB] FAIL clr_hit_recapture: got p=%0d r=%0d stamp=%0d irq=%b, expected p=3 r=3 stamp=%0d irq=1", first_prop, first_rep, first_stamp, irq, e.fs);
    end
    step(0, 0, 8'h00, 16'h0, 4'hF, 1);
    e = sbq.pop_front();
    n_cmp++;
    if (irq !== 1'b0 || sticky !== 16'h0 || viol_cnt !== 64'h0 || first_valid !== 1'b0 ||
        first_prop !== 2'd0 || first_rep !== 2'd0 || first_stamp !== 16'h0) begin
      n_fail++; $display("[TB] FAIL clr_alone: got irq=%b sticky=%h viol=%h v=%b stamp=%0d, expected all 0", irq, sticky, viol_cnt, first_valid, first_stamp);
    end
  endtask

  task automatic test_saturation();
    step(0, 1, 8'h00, 16'h0, 4'hF, 0);
    e = sbq.pop_front();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'(i), 16'h0001, 4'hF, 0);
      e = sbq.pop_front();
      n_cmp++;
      if (s_viol_cnt !== e.viol4 || s_sym_cnt !== e.scnt[3:0] || viol_cnt !== e.viol) begin
        n_fail++; $display("[TB] FAIL sat_cycle_%0d: got v4=%h c4=%0d v=%h, expected v4=%h c4=%0d v=%h", i, s_viol_cnt, s_sym_cnt, viol_cnt, e.viol4, e.scnt[3:0], e.viol);
      end
    end
    n_cmp++;
    if (s_viol_cnt[3:0] !== 4'd15 || s_sym_cnt !== 4'd4 || viol_cnt[15:0] !== 16'd20) begin
      n_fail++; $display("[TB] FAIL sat_final: got v4=%0d c4=%0d v16=%0d, expected 15 4 20", s_viol_cnt[3:0], s_sym_cnt, viol_cnt[15:0]);
    end
    step(0, 0, 8'h00, 16'h0, 4'hF, 1);
    e = sbq.pop_front();
  endtask

  task automatic test_async_reset();
    step(1, 0, 8'h5A, 16'h0020, 4'hF, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (irq !== 1'b1 || sticky !== 16'h0020) begin
      n_fail++; $display("[TB] FAIL prereset_state: got irq=%b sticky=%h, expected 1 0020", irq, sticky);
    end
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({out_symbols, rep_q, sticky, viol_cnt, sym_cnt, first_valid, first_stamp, irq} !== '0 ||
        {s_sticky, s_sym_cnt, s_irq} !== '0) begin
      n_fail++; $display("[TB] FAIL async_reset: got sym=%h sticky=%h cnt=%0d irq=%b, expected all 0", out_symbols, sticky, sym_cnt, irq);
    end
    @(negedge clk);
    reset_n = 1;
    model_reset();
    step(1, 0, 8'hA5, 16'h0101, 4'b1011, 0);
    e = sbq.pop_front();
    n_cmp++;
    if (sticky !== 16'h0001 || rep_q !== 16'h0001 || sticky !== e.sticky || first_prop !== 2'd0) begin
      n_fail++; $display("[TB] FAIL mask_after_reset: got sticky=%h rep_q=%h, expected 0001 0001", sticky, rep_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rp;
    for (int i = 0; i < 80; i++) begin
      rp = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15)) : 16'h0;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 8'($urandom),
           rp, 4'($urandom), 1'($urandom_range(0, 7) == 0));
      e = sbq.pop_front();
      n_cmp++;
      if (out_symbols !== e.sym || out_sym_reset !== e.srst || rep_q !== e.rep || sticky !== e.sticky ||
          viol_cnt !== e.viol || sym_cnt !== e.scnt || s_viol_cnt !== e.viol4 || s_sym_cnt !== e.scnt[3:0]) begin
        n_fail++; $display("[TB] FAIL b2b_data_%0d: got sym=%h rep=%h st=%h v=%h c=%0d, expected sym=%h rep=%h st=%h v=%h c=%0d", i, out_symbols, rep_q, sticky, viol_cnt, sym_cnt, e.sym, e.rep, e.sticky, e.viol, e.scnt);
      end
      n_cmp++;
      if (first_valid !== e.fv || first_prop !== e.fp || first_rep !== e.fr || first_stamp !== e.fs ||
          irq !== e.irq || s_first_stamp !== e.fs[3:0]) begin
        n_fail++; $display("[TB] FAIL b2b_capture_%0d: got v=%b p=%0d r=%0d s=%0d irq=%b, expected v=%b p=%0d r=%0d s=%0d irq=%b", i, first_valid, first_prop, first_rep, first_stamp, irq, e.fv, e.fp, e.fr, e.fs, e.irq);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_capture();
    test_clr_in_capt();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
